// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - button-sequenced operand/opcode loader and result latch for the mini ALU
module alu_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sw,
  input  logic       btn,
  input  logic [5:0] alu_out,
  output logic [5:0] a,
  output logic [5:0] b,
  output logic [2:0] fxn,
  output logic [5:0] result,
  output logic       result_valid,
  output logic [1:0] state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    LOAD_F = 2'd2,
    SHOW   = 2'd3
  } state_t;

  state_t          st_q;
  state_t          st_d;
  logic            s1;
  logic            s2;
  logic            stable;
  logic            stable_d;
  logic [CW-1:0]   cnt;
  logic            press;
  logic            ld_a;
  logic            ld_b;
  logic            ld_f;
  logic            capture;
  logic            clr_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // A change is accepted only after the synchronized level differs from
  // the accepted level for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      stable_d <= stable;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = stable & ~stable_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= LOAD_A;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    if (press) begin
      case (st_q)
        LOAD_A:  st_d = LOAD_B;
        LOAD_B:  st_d = LOAD_F;
        LOAD_F:  st_d = SHOW;
        default: st_d = LOAD_A;
      endcase
    end
  end

  // result_valid is low on entry to SHOW, so it doubles as the
  // "not yet captured" marker for the first SHOW cycle.
  always_comb begin
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_f      = 1'b0;
    capture   = 1'b0;
    clr_valid = 1'b0;
    case (st_q)
      LOAD_A: ld_a = press;
      LOAD_B: ld_b = press;
      LOAD_F: ld_f = press;
      default: begin
        capture   = ~result_valid & ~press;
        clr_valid = press;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a            <= '0;
      b            <= '0;
      fxn          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      if (ld_a) a <= sw;
      if (ld_b) b <= sw;
      if (ld_f) fxn <= sw[2:0];
      if (capture) result <= alu_out;
      if (ld_a || clr_valid) begin
        result_valid <= 1'b0;
      end else if (capture) begin
        result_valid <= 1'b1;
      end
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - scoreboard bench for alu_operand_sequencer
module tb_alu_operand_sequencer;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic [5:0] sw = '0;
  logic       alu_force = 1'b0;
  logic [5:0] alu_out;
  logic [5:0] a, b, result;
  logic [2:0] fxn;
  logic       result_valid;
  logic [1:0] state;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .alu_out(alu_out),
    .a(a), .b(b), .fxn(fxn), .result(result),
    .result_valid(result_valid), .state(state)
  );

  always #5 clk = ~clk;

  // Environment ALU: addition mod 64, with an override to prove result is frozen.
  assign alu_out = alu_force ? 6'h2a : 6'(a + b);

  typedef struct packed {
    logic [1:0] st;
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] f;
    logic [5:0] r;
    logic       v;
  } snap_t;

  snap_t      exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         m_st = 0;
  logic [5:0] m_a = '0, m_b = '0, m_r = '0;
  logic [2:0] m_f = '0;
  logic       m_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_model();
    snap_t s;
    s.st = m_st[1:0];
    s.a = m_a;
    s.b = m_b;
    s.f = m_f;
    s.r = m_r;
    s.v = m_v;
    exp_q.push_back(s);
  endtask

  // Reference behaviour of one accepted press; SHOW entry yields two visible events.
  task automatic model_press(input logic [5:0] v);
    case (m_st)
      0: begin m_a = v; m_v = 1'b0; m_st = 1; push_model(); end
      1: begin m_b = v; m_st = 2; push_model(); end
      2: begin
        m_f = v[2:0]; m_st = 3; push_model();
        m_r = 6'((int'(m_a) + int'(m_b)) % 64); m_v = 1'b1; push_model();
      end
      default: begin m_v = 1'b0; m_st = 0; push_model(); end
    endcase
  endtask

  task automatic model_reset();
    m_st = 0; m_a = '0; m_b = '0; m_f = '0; m_r = '0; m_v = 1'b0;
    exp_q.delete();
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [5:0] v, input int hold);
    sw = v;
    model_press(v);
    btn = 1'b1;
    cyc(hold);
    btn = 1'b0;
    cyc(N + 4);
  endtask

  // Called between edges with btn low; the next edge is e0.
  task automatic press_latency(input logic [5:0] v);
    int         old_st;
    logic [5:0] old_a;
    old_st = m_st;
    old_a = m_a;
    sw = v;
    model_press(v);
    btn = 1'b1;
    cyc(N + 2);
    chk("lat_state_early", state, old_st);
    chk("lat_a_early", a, old_a);
    cyc(1);
    chk("lat_state", state, m_st);
    chk("lat_a", a, m_a);
    cyc(N);
    btn = 1'b0;
    cyc(N + 4);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_a"}, a, 0);
    chk({tag, "_b"}, b, 0);
    chk({tag, "_fxn"}, fxn, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_valid"}, result_valid, 0);
  endtask

  initial begin : monitor
    logic [2:0] prev;
    snap_t      got;
    snap_t      e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = '0;
      end else if ({state, result_valid} != prev) begin
        prev = {state, result_valid};
        got = {state, a, b, fxn, result, result_valid};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: got %h want none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL scoreboard: got %h want %h", got, e);
          end
        end
      end
    end
  end

  initial begin : stim
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    cyc(2);
    rst = 1'b0;
    cyc(2);

    press_latency(6'd5);
    press(6'd3, N + 2);
    chk("full_b", b, 3);
    press(6'b111010, N + 2);
    chk("full_fxn", fxn, 3'b010);
    chk("full_state", state, 3);
    chk("full_result", result, 8);
    chk("full_valid", result_valid, 1);
    alu_force = 1'b1;
    cyc(3);
    chk("frozen_result", result, 8);
    alu_force = 1'b0;
    press(6'd0, N + 2);

    press(6'd63, N + 1);
    press(6'd1, N + 1);
    press(6'($urandom), N + 1);
    chk("wrap_result", result, 0);
    chk("wrap_valid", result_valid, 1);
    press(6'd0, N + 1);
    chk("wrap_state", state, 0);
    chk("wrap_valid_clr", result_valid, 0);
    chk("wrap_result_held", result, 0);
    chk("wrap_a_kept", a, 63);

    btn = 1'b1; cyc(3);
    btn = 1'b0; cyc(1);
    btn = 1'b1; cyc(3);
    btn = 1'b0; cyc(N + 6);
    chk("bounce_state", state, 0);
    press(6'd17, 10);
    chk("hold_state", state, 1);
    chk("hold_a", a, 17);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        btn = 1'b1;
        cyc($urandom_range(1, N - 1));
        btn = 1'b0;
        cyc(2);
      end
      press(6'($urandom), $urandom_range(N, N + 6));
    end

    while (m_st != 2) press(6'($urandom), N + 1);
    btn = 1'b1;
    cyc(2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("midrst");
    model_reset();
    cyc(2);
    sw = 6'd41;
    model_press(6'd41);
    rst = 1'b0;
    cyc(N + 2);
    chk("midrst_a_early", a, 0);
    chk("midrst_state_early", state, 0);
    cyc(1);
    chk("midrst_a", a, 41);
    chk("midrst_state", state, 1);
    cyc(20);
    chk("midrst_one_press", state, 1);
    btn = 1'b0;
    cyc(N + 6);

    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
